// File: rtl/gpr_wb_sched.sv
// Write-back scheduler and scoreboard for the 32x32 register file.
// Arbitrates the single RF write port between the main pipe write-back
// (always wins) and a small FIFO of long-latency results, tracks registers
// with an outstanding long-latency write, and throttles the main pipe via
// wb_block when buffered results have been starved too long.
module gpr_wb_sched #(
   parameter int FIFO_DEPTH   = 2,
   parameter int STARVE_LIMIT = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        issue_valid,
   input  logic [4:0]  issue_rj,
   input  logic [4:0]  issue_rkd,
   input  logic [4:0]  issue_rd,
   input  logic        issue_rd_we,
   input  logic        issue_is_long,
   output logic        issue_stall,
   input  logic        wb_valid,
   input  logic [4:0]  wb_rd,
   input  logic [31:0] wb_data,
   output logic        wb_block,
   input  logic        ll_valid,
   input  logic [4:0]  ll_rd,
   input  logic [31:0] ll_data,
   output logic        ll_ready,
   output logic        rf_we,
   output logic [4:0]  rf_rd,
   output logic [31:0] rf_data
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL_CNT  = CW'(FIFO_DEPTH);
   localparam logic [4:0]    LIMIT_CNT = 5'(STARVE_LIMIT);

   // FIFO storage carries data only, so it is not reset
   logic [4:0]    rd_mem_q   [FIFO_DEPTH];
   logic [4:0]    rd_mem_d   [FIFO_DEPTH];
   logic [31:0]   data_mem_q [FIFO_DEPTH];
   logic [31:0]   data_mem_d [FIFO_DEPTH];

   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic [31:0]   busy_q, busy_d;
   logic [3:0]    starve_q, starve_d;
   logic          wb_block_q, wb_block_d;

   logic          empty;
   logic          full;
   logic          push;
   logic          pop;
   logic          inc;
   logic          clear;
   logic [4:0]    head_rd;
   logic [31:0]   head_data;
   logic [31:0]   popmask;
   logic [31:0]   eff;
   logic [31:0]   setmask;
   logic          issue_acc;
   logic [4:0]    starve_sum;

   // FIFO status, handshake and write-port arbitration (main pipe has priority)
   always_comb begin
      empty     = (count_q == '0);
      full      = (count_q == FULL_CNT);
      ll_ready  = !full;
      push      = ll_valid && !full;
      head_rd   = rd_mem_q[rd_ptr_q];
      head_data = data_mem_q[rd_ptr_q];
      pop       = !wb_valid && !empty;
      rf_we     = 1'b0;
      rf_rd     = 5'd0;
      rf_data   = 32'd0;
      if (wb_valid) begin
         rf_we   = 1'b1;
         rf_rd   = wb_rd;
         rf_data = wb_data;
      end else if (!empty) begin
         rf_we   = 1'b1;
         rf_rd   = head_rd;
         rf_data = head_data;
      end
   end

   // Hazard check against the scoreboard, releasing the register popped this
   // cycle since the RF forwards same-cycle writes
   always_comb begin
      popmask     = pop ? (32'd1 << head_rd) : 32'd0;
      eff         = busy_q & ~popmask;
      issue_stall = issue_valid &&
                    (eff[issue_rj] | eff[issue_rkd] | (issue_rd_we & eff[issue_rd]));
      issue_acc   = issue_valid && !issue_stall;
      setmask     = (issue_acc && issue_is_long && issue_rd_we && (issue_rd != 5'd0))
                    ? (32'd1 << issue_rd) : 32'd0;
      busy_d      = ((busy_q & ~popmask) | setmask) & 32'hFFFF_FFFE;
   end

   // FIFO pointer, occupancy and storage next-state
   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      rd_mem_d   = rd_mem_q;
      data_mem_d = data_mem_q;
      if (push) begin
         rd_mem_d[wr_ptr_q]   = ll_rd;
         data_mem_d[wr_ptr_q] = ll_data;
         wr_ptr_d             = wr_ptr_q + AW'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
      end
      count_d = count_q + CW'(push) - CW'(pop);
   end

   // Starvation counter; wb_block drops the cycle after any pop
   always_comb begin
      inc        = !empty && wb_valid;
      clear      = pop || empty;
      starve_sum = {1'b0, starve_q} + 5'(inc);
      starve_d   = 4'd0;
      wb_block_d = 1'b0;
      if (!clear) begin
         starve_d   = (starve_sum > 5'd15) ? 4'd15 : starve_sum[3:0];
         wb_block_d = (starve_sum >= LIMIT_CNT);
      end
      wb_block = wb_block_q;
   end

   // Control state: scoreboard, FIFO pointers, starvation tracking
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         busy_q     <= '0;
         starve_q   <= '0;
         wb_block_q <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         busy_q     <= busy_d;
         starve_q   <= starve_d;
         wb_block_q <= wb_block_d;
      end
   end

   // Result storage
   always_ff @(posedge clk) begin
      rd_mem_q   <= rd_mem_d;
      data_mem_q <= data_mem_d;
   end

endmodule

// File: tb/tb_gpr_wb_sched.sv
// Directed bench for gpr_wb_sched: reset, long-latency write-back, RAW/WAW
// scoreboard, starvation/wb_block, full-FIFO handshake and mid-run reset.
module tb_gpr_wb_sched;

   logic        clk;
   logic        rst;
   logic        issue_valid;
   logic [4:0]  issue_rj;
   logic [4:0]  issue_rkd;
   logic [4:0]  issue_rd;
   logic        issue_rd_we;
   logic        issue_is_long;
   logic        issue_stall;
   logic        wb_valid;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;
   logic        wb_block;
   logic        ll_valid;
   logic [4:0]  ll_rd;
   logic [31:0] ll_data;
   logic        ll_ready;
   logic        rf_we;
   logic [4:0]  rf_rd;
   logic [31:0] rf_data;

   int vec;
   int errs;

   gpr_wb_sched #(.FIFO_DEPTH(2), .STARVE_LIMIT(8)) dut (
      .clk(clk), .rst(rst),
      .issue_valid(issue_valid), .issue_rj(issue_rj), .issue_rkd(issue_rkd),
      .issue_rd(issue_rd), .issue_rd_we(issue_rd_we), .issue_is_long(issue_is_long),
      .issue_stall(issue_stall),
      .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .wb_block(wb_block),
      .ll_valid(ll_valid), .ll_rd(ll_rd), .ll_data(ll_data), .ll_ready(ll_ready),
      .rf_we(rf_we), .rf_rd(rf_rd), .rf_data(rf_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Commit must not write back while wb_block is high
   always @(posedge clk) begin
      if (!rst) begin
         assert (!(wb_valid && wb_block)) else $error("protocol: wb_valid driven while wb_block");
      end
   end

   initial begin
      #200000;
      $display("FAIL timeout reached");
      $fatal(1, "timeout");
   end

   task automatic idle();
      issue_valid = 1'b0; issue_rj = 5'd0; issue_rkd = 5'd0; issue_rd = 5'd0;
      issue_rd_we = 1'b0; issue_is_long = 1'b0;
      wb_valid = 1'b0; wb_rd = 5'd0; wb_data = 32'd0;
      ll_valid = 1'b0; ll_rd = 5'd0; ll_data = 32'd0;
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      idle();
      step(); step();
      wb_valid = 1'b1; wb_rd = 5'd9; wb_data = 32'h1234_5678;
      #1;
      vec++; if (rf_we !== 1'b1 || rf_rd !== 5'd9 || rf_data !== 32'h1234_5678) begin
         errs++; $display("FAIL reset_rf_follow got we=%b rd=%0d data=%h exp we=1 rd=9 data=12345678", rf_we, rf_rd, rf_data); end
      step();
      rst = 1'b0;
      idle();
      issue_valid = 1'b1; issue_rj = 5'd1; issue_rkd = 5'd2;
      #1;
      vec++; if (ll_ready !== 1'b1) begin errs++; $display("FAIL reset_ll_ready got %b exp 1", ll_ready); end
      vec++; if (wb_block !== 1'b0) begin errs++; $display("FAIL reset_wb_block got %b exp 0", wb_block); end
      vec++; if (issue_stall !== 1'b0) begin errs++; $display("FAIL reset_stall got %b exp 0", issue_stall); end
      vec++; if (rf_we !== 1'b0) begin errs++; $display("FAIL reset_rf_we got %b exp 0", rf_we); end
   endtask

   task automatic test_ll_basic();
      step(); idle();
      ll_valid = 1'b1; ll_rd = 5'd5; ll_data = 32'h0000_DEAD;
      #1;
      vec++; if (rf_we !== 1'b0) begin errs++; $display("FAIL ll_no_bypass got %b exp 0", rf_we); end
      step(); idle();
      #1;
      vec++; if (rf_we !== 1'b1 || rf_rd !== 5'd5 || rf_data !== 32'h0000_DEAD) begin
         errs++; $display("FAIL ll_write got we=%b rd=%0d data=%h exp we=1 rd=5 data=0000dead", rf_we, rf_rd, rf_data); end
      step();
      #1;
      vec++; if (rf_we !== 1'b0) begin errs++; $display("FAIL ll_drained got %b exp 0", rf_we); end
   endtask

   task automatic test_raw();
      step(); idle();
      issue_valid = 1'b1; issue_rd = 5'd7; issue_rd_we = 1'b1; issue_is_long = 1'b1;
      issue_rj = 5'd1; issue_rkd = 5'd2;
      #1;
      vec++; if (issue_stall !== 1'b0) begin errs++; $display("FAIL raw_issue_long got %b exp 0", issue_stall); end
      step(); idle();
      issue_valid = 1'b1; issue_rj = 5'd7; issue_rkd = 5'd2; issue_rd = 5'd8; issue_rd_we = 1'b1;
      #1;
      vec++; if (issue_stall !== 1'b1) begin errs++; $display("FAIL raw_stall got %b exp 1", issue_stall); end
      step();
      ll_valid = 1'b1; ll_rd = 5'd7; ll_data = 32'h0000_0077;
      #1;
      vec++; if (issue_stall !== 1'b1) begin errs++; $display("FAIL raw_stall_on_push got %b exp 1", issue_stall); end
      step();
      ll_valid = 1'b0;
      #1;
      vec++; if (issue_stall !== 1'b0) begin errs++; $display("FAIL raw_release got %b exp 0", issue_stall); end
      vec++; if (rf_we !== 1'b1 || rf_rd !== 5'd7 || rf_data !== 32'h0000_0077) begin
         errs++; $display("FAIL raw_pop got we=%b rd=%0d data=%h exp we=1 rd=7 data=00000077", rf_we, rf_rd, rf_data); end
      step(); idle();
      issue_valid = 1'b1; issue_rj = 5'd7; issue_rkd = 5'd7; issue_rd = 5'd7; issue_rd_we = 1'b1;
      #1;
      vec++; if (issue_stall !== 1'b0) begin errs++; $display("FAIL raw_cleared got %b exp 0", issue_stall); end
   endtask

   task automatic test_starve_full();
      step(); idle();
      wb_valid = 1'b1; wb_rd = 5'd1; wb_data = 32'h0000_0101;
      ll_valid = 1'b1; ll_rd = 5'd10; ll_data = 32'h0000_00A0;
      #1;
      vec++; if (rf_rd !== 5'd1 || rf_data !== 32'h0000_0101) begin
         errs++; $display("FAIL starve_wb_wins got rd=%0d data=%h exp rd=1 data=00000101", rf_rd, rf_data); end
      step();
      ll_rd = 5'd11; ll_data = 32'h0000_00B1;
      #1;
      vec++; if (ll_ready !== 1'b1) begin errs++; $display("FAIL starve_ready_1 got %b exp 1", ll_ready); end
      for (int i = 2; i <= 8; i++) begin
         step();
         ll_valid = 1'b0;
         #1;
         vec++; if (ll_ready !== 1'b0) begin errs++; $display("FAIL starve_full_%0d got %b exp 0", i, ll_ready); end
         vec++; if (wb_block !== 1'b0) begin errs++; $display("FAIL starve_block_early_%0d got %b exp 0", i, wb_block); end
      end
      step();
      wb_valid = 1'b0;
      ll_valid = 1'b1; ll_rd = 5'd12; ll_data = 32'h0000_00C2;
      #1;
      vec++; if (wb_block !== 1'b1) begin errs++; $display("FAIL starve_block got %b exp 1", wb_block); end
      vec++; if (ll_ready !== 1'b0) begin errs++; $display("FAIL full_pop_ready got %b exp 0", ll_ready); end
      vec++; if (rf_we !== 1'b1 || rf_rd !== 5'd10 || rf_data !== 32'h0000_00A0) begin
         errs++; $display("FAIL fifo_head0 got we=%b rd=%0d data=%h exp we=1 rd=10 data=000000a0", rf_we, rf_rd, rf_data); end
      step();
      #1;
      vec++; if (wb_block !== 1'b0) begin errs++; $display("FAIL starve_unblock got %b exp 0", wb_block); end
      vec++; if (ll_ready !== 1'b1) begin errs++; $display("FAIL full_pop_ready_next got %b exp 1", ll_ready); end
      vec++; if (rf_rd !== 5'd11 || rf_data !== 32'h0000_00B1) begin
         errs++; $display("FAIL fifo_head1 got rd=%0d data=%h exp rd=11 data=000000b1", rf_rd, rf_data); end
      step();
      ll_valid = 1'b0;
      #1;
      vec++; if (rf_we !== 1'b1 || rf_rd !== 5'd12 || rf_data !== 32'h0000_00C2) begin
         errs++; $display("FAIL fifo_head2 got we=%b rd=%0d data=%h exp we=1 rd=12 data=000000c2", rf_we, rf_rd, rf_data); end
      step();
      #1;
      vec++; if (rf_we !== 1'b0) begin errs++; $display("FAIL fifo_empty got %b exp 0", rf_we); end
   endtask

   task automatic test_r0_waw();
      step(); idle();
      issue_valid = 1'b1; issue_rd = 5'd0; issue_rd_we = 1'b1; issue_is_long = 1'b1;
      #1;
      vec++; if (issue_stall !== 1'b0) begin errs++; $display("FAIL r0_issue got %b exp 0", issue_stall); end
      step();
      issue_is_long = 1'b0;
      #1;
      vec++; if (issue_stall !== 1'b0) begin errs++; $display("FAIL r0_no_stall got %b exp 0", issue_stall); end
      step();
      issue_rj = 5'd1; issue_rkd = 5'd2; issue_rd = 5'd3; issue_rd_we = 1'b1; issue_is_long = 1'b1;
      #1;
      vec++; if (issue_stall !== 1'b0) begin errs++; $display("FAIL waw_first got %b exp 0", issue_stall); end
      step();
      #1;
      vec++; if (issue_stall !== 1'b1) begin errs++; $display("FAIL waw_second got %b exp 1", issue_stall); end
      issue_rd_we = 1'b0;
      #1;
      vec++; if (issue_stall !== 1'b0) begin errs++; $display("FAIL waw_no_we got %b exp 0", issue_stall); end
      step();
      issue_rd = 5'd4; issue_rd_we = 1'b1; issue_is_long = 1'b1;
      #1;
      vec++; if (issue_stall !== 1'b0) begin errs++; $display("FAIL busy4_issue got %b exp 0", issue_stall); end
   endtask

   task automatic test_mid_reset();
      step(); idle();
      issue_valid = 1'b1; issue_rj = 5'd4; issue_rkd = 5'd0;
      #1;
      vec++; if (issue_stall !== 1'b1) begin errs++; $display("FAIL busy4_set got %b exp 1", issue_stall); end
      issue_valid = 1'b0;
      wb_valid = 1'b1; wb_rd = 5'd2; wb_data = 32'h2;
      ll_valid = 1'b1; ll_rd = 5'd20; ll_data = 32'h20;
      step();
      ll_rd = 5'd21; ll_data = 32'h21;
      step();
      ll_valid = 1'b0;
      #1;
      vec++; if (ll_ready !== 1'b0) begin errs++; $display("FAIL mid_full got %b exp 0", ll_ready); end
      wb_valid = 1'b0;
      rst = 1'b1;
      issue_valid = 1'b1; issue_rj = 5'd4; issue_rkd = 5'd0;
      #1;
      vec++; if (ll_ready !== 1'b1) begin errs++; $display("FAIL mid_rst_ready got %b exp 1", ll_ready); end
      vec++; if (rf_we !== 1'b0) begin errs++; $display("FAIL mid_rst_rf_we got %b exp 0", rf_we); end
      vec++; if (issue_stall !== 1'b0) begin errs++; $display("FAIL mid_rst_stall got %b exp 0", issue_stall); end
      step();
      rst = 1'b0;
      issue_rj = 5'd3;
      #1;
      vec++; if (issue_stall !== 1'b0 || rf_we !== 1'b0) begin
         errs++; $display("FAIL post_rst got stall=%b we=%b exp stall=0 we=0", issue_stall, rf_we); end
      step();
      #1;
      vec++; if (rf_we !== 1'b0 || ll_ready !== 1'b1) begin
         errs++; $display("FAIL post_rst_idle got we=%b ready=%b exp we=0 ready=1", rf_we, ll_ready); end
   endtask

   initial begin
      vec  = 0;
      errs = 0;
      rst  = 1'b1;
      idle();
      test_reset();
      test_ll_basic();
      test_raw();
      test_starve_full();
      test_r0_waw();
      test_mid_reset();
      step(); idle();
      $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
      $finish;
   end

endmodule

// File: doc/gpr_wb_sched.md
# gpr_wb_sched

Write-back scheduler and scoreboard for the 32×32 general register file, which has one write port. Per cycle it arbitrates that port between the in-order main pipeline write-back and a buffered long-latency unit (mul/div/load-miss). It tracks registers with an outstanding long-latency write and stalls decode on RAW/WAW hazards against them. It sits between decode/commit and the register file; its `rf_*` outputs drive the register file write port directly.

## Interface
- `FIFO_DEPTH`, default 2: long-latency result buffer entries; power of two, ≥2.
- `STARVE_LIMIT`, default 8: consecutive lost arbitration cycles before `wb_block` asserts; range 1..15.

Ports:
- `clk`  in  1  clock; all state on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `issue_valid`  in  1  decode presents an instruction.
- `issue_rj`, `issue_rkd`  in  5 each  source register indices.
- `issue_rd`  in  5  destination index.
- `issue_rd_we`  in  1  instruction writes `issue_rd`.
- `issue_is_long`  in  1  the destination is produced by the long-latency unit.
- `issue_stall`  out  1  hazard; decode must hold. Issue is accepted when `issue_valid && !issue_stall`.
- `wb_valid`, `wb_rd`(5), `wb_data`(32)  in  main-pipe write-back; never back-pressured.
- `wb_block`  out  1  registered; commit must not drive `wb_valid` in a cycle where this is 1.
- `ll_valid`, `ll_rd`(5), `ll_data`(32)  in  long-latency result.
- `ll_ready`  out  1  FIFO can accept. Transfer occurs when `ll_valid && ll_ready`.
- `rf_we`, `rf_rd`(5), `rf_data`(32)  out  register file write port.

## Operation
- Scoreboard: `busy[31:0]`. `busy[0]` is hard 0.
  - On an accepted issue with `issue_is_long && issue_rd_we && issue_rd!=0`: set `busy[issue_rd]`.
  - On a FIFO pop: clear `busy[head.rd]`.
- Stall: `issue_stall = issue_valid && (eff[rj] | eff[rkd] | (issue_rd_we & eff[rd]))`, where `eff = busy & ~popmask` and `popmask` is the one-hot of the register being popped this cycle. Same-cycle release is legal because the register file forwards same-cycle writes.
- FIFO (`FIFO_DEPTH` entries of {rd, data}):
  - Push on `ll_valid && ll_ready`.
  - `ll_ready = !full`, computed from registered occupancy only.
  - Push and pop in the same cycle are allowed at any occupancy other than full. When full, no push-through.
- Arbitration (combinational):
  - If `wb_valid`: `rf_* = wb_*`.
  - Else if FIFO non-empty: `rf_* = head`, pop.
  - Else `rf_we = 0`, `rf_rd = 0`, `rf_data = 0`.
  - There is no bypass from `ll_*` straight to `rf_*`.
- `rd==0` writes pass through unchanged; the register file ignores them.
- Starvation counter `starve`:
  - Increments when the FIFO is non-empty and `wb_valid` wins.
  - Clears on any pop or when the FIFO is empty.
  - `wb_block` next cycle = (`starve+inc >= STARVE_LIMIT`). It stays 1 until the cycle after a pop.
  - If `wb_valid` arrives while `wb_block` is 1, wb still wins. This is a protocol violation, flagged by a bench assertion.

## Timing
- Reset values (async): `busy=0`, FIFO empty, `starve=0`, `wb_block=0`, so `ll_ready=1` and `issue_stall` is combinational from inputs only. During reset `rf_*` follow `wb_*`. Reset mid-operation discards buffered results and scoreboard state.
- Long-latency accepted in cycle N with no competing wb: written in N+1. Earliest unstall of a dependent instruction: N+1.
- Scoreboard set is visible to `issue_stall` the cycle after issue. A same-cycle back-to-back dependent issue is the main pipe's own forwarding concern and is not tracked here.
- Main wb latency 0 (combinational pass-through).
- Duplicate destinations cannot be outstanding: the WAW stall prevents it.

## Test plan
- Reset → `ll_ready=1`, `wb_block=0`, `issue_stall=0` for rj=1, rkd=2; `ll_valid` r5=0xDEAD at N with `wb_valid=0` → `rf_we=1`, rd=5, data=0xDEAD at N+1.
- Issue long r7. Then issue `add` with rj=7 → `issue_stall=1`. When `ll` r7 pops in cycle M → `issue_stall=0` in M, `rf_rd=7`.
- `wb_valid` every cycle with 2 `ll` results buffered → `ll_ready=0`. After 8 lost cycles `wb_block=1`. Bench drops `wb_valid` → head pops, `starve=0`, `wb_block=0` the next cycle.
- FIFO full plus a pop in the same cycle → `ll_ready` stays 0 that cycle, 1 the next. No entry lost; order is FIFO.
- Issue long r0 → `busy` unchanged; a later `rj=0` never stalls. Issue long r3, then long r3 again → second issue stalls (WAW).
- Assert `rst` with 2 entries buffered and `busy[4]=1` → immediately `ll_ready=1`, no `rf_we` from the FIFO, and `rj=4` does not stall.
